// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl
//
// Boot-loader controller that sits behind the UART receiver. It parses a
// framed byte stream into 32-bit word writes and holds the CPU in reset
// while loading. When a frame is loaded and its checksum matches, it
// releases the CPU with the frame base address as the entry PC.
//
// Frame layout:
//   SYNC, ADDR[4] (LE), LEN[2] (LE word count N), DATA[4*N] (LE words), CSUM
//   CSUM is the mod-256 sum of every byte after SYNC and before CSUM.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   i_rx_data/valid     byte stream from the UART receiver
//   o_rx_ready          a byte is taken when i_rx_valid & o_rx_ready
//   i_rx_frame_error    one-cycle receiver frame-error pulse
//   i_rx_overrun_error  one-cycle receiver overrun pulse
//   o_mem_addr/wdata    word write toward instruction/data RAM
//   o_mem_valid         write request; taken when o_mem_valid & i_mem_ready
//   o_core_reset        holds the CPU in reset
//   o_entry_pc          load base address, meaningful while o_done
//   o_busy              a frame is in progress
//   o_done / o_error    sticky status of the last frame
//   o_err_code          0 none, 1 checksum, 2 UART line error, 3 timeout
//
// Optional build macro UART_LOADER_ACK_EN adds o_tx_data/o_tx_valid/
// i_tx_ready. It sends 'K' on success, or 'E' followed by '0'+code on
// failure. Without the macro those ports do not exist.
module uart_loader_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic        i_rx_frame_error,
    input  logic        i_rx_overrun_error,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic        o_core_reset,
    output logic [31:0] o_entry_pc,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_err_code
`ifdef UART_LOADER_ACK_EN
    ,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
`endif
);

    typedef enum logic [2:0] {
        IDLE, ADDR, LEN, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    localparam logic [1:0]  ERR_CSUM = 2'd1;
    localparam logic [1:0]  ERR_LINE = 2'd2;
    localparam logic [1:0]  ERR_TMO  = 2'd3;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [32:0] TMO_LIM  = 33'(TIMEOUT_CYCLES) - 33'd1;

    state_t      state, state_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] base, base_n;
    logic [15:0] len, len_n;          // LEN shift register, then remaining words
    logic [7:0]  sum, sum_n;
    logic [31:0] tmo, tmo_n;

    logic [31:0] mem_addr_n, mem_wdata_n, entry_pc_n;
    logic        mem_valid_n, core_reset_n, busy_n, done_n, error_n;
    logic [1:0]  err_code_n;

    logic        rx_acc, line_err, tmo_hit, fail;
    logic [1:0]  fail_code;

    assign o_rx_ready = !rst && (state != WRITE);
    assign rx_acc     = i_rx_valid && o_rx_ready;
    assign line_err   = i_rx_frame_error || i_rx_overrun_error;
    // Fires on the cycle whose increment would make the idle count reach
    // TIMEOUT_CYCLES-1.
    assign tmo_hit    = TMO_EN && (({1'b0, tmo} + 33'd1) >= TMO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            base         <= '0;
            len          <= '0;
            sum          <= '0;
            tmo          <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_valid  <= 1'b0;
            o_core_reset <= 1'b1;
            o_entry_pc   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_code   <= '0;
        end else begin
            state        <= state_n;
            byte_cnt     <= byte_cnt_n;
            base         <= base_n;
            len          <= len_n;
            sum          <= sum_n;
            tmo          <= tmo_n;
            o_mem_addr   <= mem_addr_n;
            o_mem_wdata  <= mem_wdata_n;
            o_mem_valid  <= mem_valid_n;
            o_core_reset <= core_reset_n;
            o_entry_pc   <= entry_pc_n;
            o_busy       <= busy_n;
            o_done       <= done_n;
            o_error      <= error_n;
            o_err_code   <= err_code_n;
        end
    end

    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        base_n       = base;
        len_n        = len;
        sum_n        = sum;
        tmo_n        = tmo;
        mem_addr_n   = o_mem_addr;
        mem_wdata_n  = o_mem_wdata;
        mem_valid_n  = o_mem_valid;
        core_reset_n = o_core_reset;
        entry_pc_n   = o_entry_pc;
        busy_n       = o_busy;
        done_n       = o_done;
        error_n      = o_error;
        err_code_n   = o_err_code;
        fail         = 1'b0;
        fail_code    = 2'd0;

        unique case (state)
            IDLE, DONE, ERROR: begin
                // Only a SYNC byte starts a frame; anything else is dropped.
                if (rx_acc && (i_rx_data == SYNC_BYTE)) begin
                    state_n      = ADDR;
                    byte_cnt_n   = '0;
                    sum_n        = '0;
                    done_n       = 1'b0;
                    error_n      = 1'b0;
                    err_code_n   = '0;
                    core_reset_n = 1'b1;
                    busy_n       = 1'b1;
                end
            end
            WRITE: begin
                // Line errors are ignored here, so the write in flight
                // always completes.
                if (i_mem_ready) begin
                    mem_valid_n = 1'b0;
                    mem_addr_n  = o_mem_addr + 32'd4;
                    len_n       = len - 16'd1;
                    state_n     = (len == 16'd1) ? CHECK : DATA;
                end
            end
            default: begin
                // ADDR, LEN, DATA, CHECK
                // Priority: line error, then timeout, then byte processing.
                if (line_err) begin
                    fail      = 1'b1;
                    fail_code = ERR_LINE;
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end else if (rx_acc) begin
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (state != CHECK) begin
                        sum_n = sum + i_rx_data;
                    end
                    case (state)
                        ADDR: begin
                            base_n = {i_rx_data, base[31:8]};
                            if (byte_cnt == 2'd3) begin
                                base_n[1:0] = 2'b00;
                                mem_addr_n  = base_n;
                                byte_cnt_n  = '0;
                                state_n     = LEN;
                            end
                        end
                        LEN: begin
                            len_n = {i_rx_data, len[15:8]};
                            if (byte_cnt == 2'd1) begin
                                byte_cnt_n = '0;
                                state_n    = (len_n != '0) ? DATA : CHECK;
                            end
                        end
                        DATA: begin
                            mem_wdata_n = {i_rx_data, o_mem_wdata[31:8]};
                            if (byte_cnt == 2'd3) begin
                                byte_cnt_n  = '0;
                                mem_valid_n = 1'b1;
                                state_n     = WRITE;
                            end
                        end
                        CHECK: begin
                            if (i_rx_data == sum) begin
                                state_n      = DONE;
                                done_n       = 1'b1;
                                core_reset_n = 1'b0;
                                entry_pc_n   = base;
                                busy_n       = 1'b0;
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_CSUM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        if (fail) begin
            state_n      = ERROR;
            error_n      = 1'b1;
            err_code_n   = fail_code;
            busy_n       = 1'b0;
            core_reset_n = 1'b1;
        end

        // The idle counter restarts on every accepted byte and on every
        // state change. It is frozen while a write is outstanding.
        if (rx_acc || (state_n != state) ||
            (state == IDLE) || (state == DONE) || (state == ERROR)) begin
            tmo_n = '0;
        end else if (state != WRITE) begin
            tmo_n = tmo + 32'd1;
        end
    end

`ifdef UART_LOADER_ACK_EN
    logic       tx_pend;
    logic [7:0] tx_pend_data;
    logic       enter_done, enter_error, restart;

    assign enter_done  = (state_n == DONE)  && (state != DONE);
    assign enter_error = (state_n == ERROR) && (state != ERROR);
    assign restart     = (state_n == ADDR) &&
                         ((state == IDLE) || (state == DONE) || (state == ERROR));

    // A new SYNC wins over any acknowledge still being sent.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            tx_pend      <= 1'b0;
            tx_pend_data <= '0;
        end else if (enter_done) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= 8'h4B;
            tx_pend    <= 1'b0;
        end else if (enter_error) begin
            o_tx_valid   <= 1'b1;
            o_tx_data    <= 8'h45;
            tx_pend      <= 1'b1;
            tx_pend_data <= 8'h30 + {6'd0, err_code_n};
        end else if (o_tx_valid && i_tx_ready) begin
            if (tx_pend) begin
                o_tx_data <= tx_pend_data;
                tx_pend   <= 1'b0;
            end else begin
                o_tx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Testbench for uart_loader_ctrl (default build, TIMEOUT_CYCLES = 100).
// Directed frames from the loader's test plan, followed by randomized
// frames. Expectations come from a frame-level reference model: it builds
// the byte stream, the expected word writes, and the expected status.
`timescale 1ns/1ps
module tb_uart_loader_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        core_reset;
    logic [31:0] entry_pc;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0]  fbytes[$];
    logic [31:0] fwords[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] obs_addr[$], obs_data[$];

    bit          stall_rand  = 1'b0;
    int          stall_fixed = 0;
    int          wcnt;
    int          stall_cur;
    logic        pend;
    logic [31:0] pa, pd;

    logic [31:0] r_addr;
    int          r_nw;
    logic [7:0]  r_xr;

    initial forever #5 clk = ~clk;

    uart_loader_ctrl #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_rx_data          (rx_data),
        .i_rx_valid         (rx_valid),
        .o_rx_ready         (rx_ready),
        .i_rx_frame_error   (frame_err),
        .i_rx_overrun_error (overrun_err),
        .o_mem_addr         (mem_addr),
        .o_mem_wdata        (mem_wdata),
        .o_mem_valid        (mem_valid),
        .i_mem_ready        (mem_ready),
        .o_core_reset       (core_reset),
        .o_entry_pc         (entry_pc),
        .o_busy             (busy),
        .o_done             (done),
        .o_error            (error),
        .o_err_code         (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && n < 300) begin
            acc = rx_ready;
            @(negedge clk);
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) chk1("rx_accept_budget", acc, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "/core_reset"}, core_reset, 1'b1);
        chk ({tag, "/entry_pc"},   entry_pc,   32'd0);
        chk ({tag, "/mem_addr"},   mem_addr,   32'd0);
        chk ({tag, "/mem_wdata"},  mem_wdata,  32'd0);
        chk1({tag, "/mem_valid"},  mem_valid,  1'b0);
        chk1({tag, "/rx_ready"},   rx_ready,   1'b0);
        chk1({tag, "/busy"},       busy,       1'b0);
        chk1({tag, "/done"},       done,       1'b0);
        chk1({tag, "/error"},      error,      1'b0);
        chk ({tag, "/err_code"},   32'(err_code), 32'd0);
    endtask

    task automatic check_result(input string tag, input bit ok, input logic [31:0] base);
        chk({tag, "/nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk($sformatf("%s/waddr%0d", tag, i), obs_addr[i], exp_addr[i]);
            chk($sformatf("%s/wdata%0d", tag, i), obs_data[i], exp_data[i]);
        end
        chk1({tag, "/done"},       done,       ok);
        chk1({tag, "/error"},      error,      !ok);
        chk ({tag, "/err_code"},   32'(err_code), ok ? 32'd0 : 32'd1);
        chk1({tag, "/core_reset"}, core_reset, !ok);
        chk1({tag, "/busy"},       busy,       1'b0);
        if (ok) chk({tag, "/entry_pc"}, entry_pc, base);
    endtask

    // Reference model: builds the frame from fwords, derives the expected
    // writes and status, and then streams the frame into the DUT.
    // The checksum sent is either a forced value or the true sum XOR xr.
    task automatic run_frame(input string tag, input logic [31:0] addr,
                             input bit force_cs, input logic [7:0] forced,
                             input logic [7:0] xr, input int gap_max);
        logic [7:0]  s, sent;
        logic [31:0] base;
        int          n;
        n    = fwords.size();
        base = addr & 32'hFFFF_FFFC;
        fbytes = {};
        fbytes.push_back(SYNC);
        for (int i = 0; i < 4; i++) fbytes.push_back(8'(addr >> (8 * i)));
        fbytes.push_back(8'(n));
        fbytes.push_back(8'(n >> 8));
        foreach (fwords[i])
            for (int k = 0; k < 4; k++) fbytes.push_back(8'(fwords[i] >> (8 * k)));
        s = 8'd0;
        for (int i = 1; i < fbytes.size(); i++) s = s + fbytes[i];
        sent = force_cs ? forced : (s ^ xr);
        fbytes.push_back(sent);
        exp_addr = {};
        exp_data = {};
        foreach (fwords[i]) begin
            exp_addr.push_back(base + 32'(4 * i));
            exp_data.push_back(fwords[i]);
        end
        obs_addr = {};
        obs_data = {};
        foreach (fbytes[i]) begin
            send_byte(fbytes[i]);
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
        end
        check_result(tag, sent == s, base);
    endtask

    // Memory-side responder and write monitor.
    initial begin
        wcnt = 0; stall_cur = 0; pend = 1'b0; pa = '0; pd = '0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                if (wcnt == 0)
                    stall_cur = stall_rand ? int'($urandom_range(0, 3)) : stall_fixed;
                mem_ready = (wcnt >= stall_cur);
                wcnt++;
                if (pend) begin
                    chk("stall/addr_stable", mem_addr, pa);
                    chk("stall/data_stable", mem_wdata, pd);
                end
                chk1("write/rx_ready_low", rx_ready, 1'b0);
                if (mem_ready) begin
                    obs_addr.push_back(mem_addr);
                    obs_data.push_back(mem_wdata);
                end
                pend = !mem_ready;
                pa   = mem_addr;
                pd   = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
                pend      = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        frame_err = 1'b0; overrun_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk1("idle/rx_ready", rx_ready, 1'b1);

        // Basic two-word frame
        fwords = {32'h12345678, 32'hDEADBEEF};
        run_frame("basic", 32'h0000_1000, 1'b0, 8'h00, 8'h00, 0);

        // Same frame, memory stalls 10 cycles per write
        stall_fixed = 10;
        run_frame("stall", 32'h0000_1000, 1'b0, 8'h00, 8'h00, 0);
        stall_fixed = 0;

        // Same frame with checksum forced to 0x00
        run_frame("badcsum", 32'h0000_1000, 1'b1, 8'h00, 8'h00, 0);

        // Garbage before SYNC is dropped
        send_byte(8'h11);
        send_byte(8'h22);
        chk1("garbage/error_kept", error, 1'b1);
        chk1("garbage/busy",       busy,  1'b0);

        // LEN = 0, unaligned address
        fwords = {};
        run_frame("len0", 32'h0000_3003, 1'b0, 8'h00, 8'h00, 0);

        // Timeout after two address bytes
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h20);
        idle(98);
        chk ("tmo/early_code",  32'(err_code), 32'd0);
        chk1("tmo/early_error", error, 1'b0);
        idle(1);
        chk ("tmo/code",       32'(err_code), 32'd3);
        chk1("tmo/error",      error,      1'b1);
        chk1("tmo/busy",       busy,       1'b0);
        chk1("tmo/core_reset", core_reset, 1'b1);
        send_byte(SYNC);
        chk1("resync/error", error, 1'b0);
        chk ("resync/code",  32'(err_code), 32'd0);
        chk1("resync/busy",  busy, 1'b1);

        // Frame error during DATA
        obs_addr = {}; obs_data = {};
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        frame_err = 1'b1;
        @(negedge clk);
        frame_err = 1'b0;
        chk ("ferr/code",       32'(err_code), 32'd2);
        chk1("ferr/error",      error,      1'b1);
        chk1("ferr/busy",       busy,       1'b0);
        chk1("ferr/core_reset", core_reset, 1'b1);
        chk ("ferr/nwrites",    32'(obs_addr.size()), 32'd0);
        overrun_err = 1'b1;
        @(negedge clk);
        overrun_err = 1'b0;
        chk ("ferr/ignored_in_error", 32'(err_code), 32'd2);

        // Reset in the middle of DATA, after one word was written
        obs_addr = {}; obs_data = {};
        send_byte(SYNC);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        chk("midrst/nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() > 0) begin
            chk("midrst/waddr", obs_addr[0], 32'h0000_2000);
            chk("midrst/wdata", obs_data[0], 32'h4433_2211);
        end
        rx_data = 8'h77; rx_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_reset("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk1("midrst/rx_ready_after", rx_ready, 1'b1);

        // Randomized frames
        stall_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            r_addr = $urandom;
            r_nw   = int'($urandom_range(0, 4));
            if (f == 2) begin
                r_addr = 32'hFFFF_FFF9;
                r_nw   = 3;
            end
            fwords = {};
            repeat (r_nw) fwords.push_back($urandom);
            r_xr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame($sformatf("rand%0d", f), r_addr, 1'b0, 8'h00, r_xr, 3);
        end
        stall_rand = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
